// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: divide sequencer states,
// forwarding select encoding and the per-operand forwarding decision.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE = 2'b00,
        HZ_BUSY = 2'b01,
        HZ_DONE = 2'b10
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Memory-stage result is younger, so it wins over Writeback; x0 never forwards.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (wr_m && (rs != 5'd0) && (rs == rd_m))
            sel = FWD_MEM;
        else if (wr_w && (rs != 5'd0) && (rs == rd_w))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Divide sequencer: holds a DIV/REM in Execute for DIV_CYCLES cycles of iteration,
// then flags the result cycle. Busy is asserted combinationally in the start cycle.
module div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_start,
    output logic div_stall,
    output logic div_done
);

    hz_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The start cycle counts as the first busy cycle, hence the load of DIV_CYCLES-2.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            HZ_IDLE: begin
                if (div_start) begin
                    state_next = HZ_BUSY;
                    cnt_next   = CNT_W'(DIV_CYCLES - 2);
                end
            end
            HZ_BUSY: begin
                if (cnt == '0)
                    state_next = HZ_DONE;
                else
                    cnt_next = cnt - CNT_W'(1);
            end
            HZ_DONE: state_next = HZ_IDLE;
            default: state_next = HZ_IDLE;
        endcase
    end

    always_comb begin
        div_stall = ((state == HZ_IDLE) && div_start) || (state == HZ_BUSY);
        div_done  = (state == HZ_DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX forwarding selects, load-use stall,
// branch flushes and the multi-cycle divide hold. Zero latency except the divide FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       DivStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       EnE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       DivBusy,
    output logic       DivDoneE
);

    logic div_stall;
    logic lw_stall;

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_div_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_start(DivStartE),
        .div_stall(div_stall),
        .div_done (DivDoneE)
    );

    always_comb begin
        ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // A held divide overrides load-use and redirect actions; FlushM bubbles EX/MEM behind it.
    always_comb begin
        DivBusy = div_stall;
        StallF  = div_stall || lw_stall;
        StallD  = div_stall || lw_stall;
        EnE     = !div_stall;
        FlushM  = div_stall;
        FlushE  = !div_stall && (lw_stall || PCSrcE);
        FlushD  = !div_stall && PCSrcE;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with DIV_CYCLES=4 and one at the
// DIV_CYCLES=2 boundary, sharing all inputs.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, DivStartE;

    logic       StallF, StallD, EnE, FlushD, FlushE, FlushM, DivBusy, DivDoneE;
    logic [1:0] ForwardAE, ForwardBE;

    logic       d2_StallF, d2_StallD, d2_EnE, d2_FlushD, d2_FlushE, d2_FlushM;
    logic       d2_DivBusy, d2_DivDoneE;
    logic [1:0] d2_ForwardAE, d2_ForwardBE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .DivStartE(DivStartE),
        .StallF(StallF), .StallD(StallD), .EnE(EnE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .DivBusy(DivBusy), .DivDoneE(DivDoneE)
    );

    hazard_ctrl #(.DIV_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .DivStartE(DivStartE),
        .StallF(d2_StallF), .StallD(d2_StallD), .EnE(d2_EnE),
        .FlushD(d2_FlushD), .FlushE(d2_FlushE), .FlushM(d2_FlushM),
        .ForwardAE(d2_ForwardAE), .ForwardBE(d2_ForwardBE),
        .DivBusy(d2_DivBusy), .DivDoneE(d2_DivDoneE)
    );

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        LoadE = 1'b0; PCSrcE = 1'b0; DivStartE = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // {StallF,StallD,FlushD,FlushE,FlushM,DivBusy,DivDoneE,EnE,ForwardAE,ForwardBE}
    task automatic test_reset();
        logic [11:0] obs;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        obs = {StallF, StallD, FlushD, FlushE, FlushM, DivBusy, DivDoneE, EnE, ForwardAE, ForwardBE};
        checks++;
        if (obs !== 12'b0000_0001_0000) begin
            errors++;
            $display("FAIL reset_outputs_dut4: got %b expected %b", obs, 12'b0000_0001_0000);
        end
        obs = {d2_StallF, d2_StallD, d2_FlushD, d2_FlushE, d2_FlushM, d2_DivBusy, d2_DivDoneE,
               d2_EnE, d2_ForwardAE, d2_ForwardBE};
        checks++;
        if (obs !== 12'b0000_0001_0000) begin
            errors++;
            $display("FAIL reset_outputs_dut2: got %b expected %b", obs, 12'b0000_0001_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forwarding();
        clear_inputs();
        Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        checks++;
        if (ForwardAE !== FWD_MEM) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %b expected %b", ForwardAE, FWD_MEM);
        end
        RegWriteM = 1'b0;
        #1;
        checks++;
        if (ForwardAE !== FWD_WB) begin
            errors++;
            $display("FAIL fwd_wb: got %b expected %b", ForwardAE, FWD_WB);
        end
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        #1;
        checks++;
        if (ForwardAE !== FWD_RF) begin
            errors++;
            $display("FAIL fwd_x0: got %b expected %b", ForwardAE, FWD_RF);
        end
        // Operand B independent of A: Rs2E hits only in Writeback, Rs1E hits only in Memory.
        Rs1E = 5'd3; Rs2E = 5'd9; RdM = 5'd3; RdW = 5'd9; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== {FWD_MEM, FWD_WB}) begin
            errors++;
            $display("FAIL fwd_split_ab: got %b expected %b", {ForwardAE, ForwardBE}, {FWD_MEM, FWD_WB});
        end
        Rs2E = 5'd10;
        #1;
        checks++;
        if (ForwardBE !== FWD_RF) begin
            errors++;
            $display("FAIL fwd_b_nomatch: got %b expected %b", ForwardBE, FWD_RF);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    // {StallF,StallD,FlushE,EnE,FlushD}
    task automatic test_load_use();
        logic [4:0] obs;
        clear_inputs();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        obs = {StallF, StallD, FlushE, EnE, FlushD};
        checks++;
        if (obs !== 5'b11110) begin
            errors++;
            $display("FAIL lw_stall_rs2: got %b expected %b", obs, 5'b11110);
        end
        @(negedge clk);
        LoadE = 1'b0; RdE = 5'd0;
        #1;
        obs = {StallF, StallD, FlushE, EnE, FlushD};
        checks++;
        if (obs !== 5'b00010) begin
            errors++;
            $display("FAIL lw_stall_one_cycle: got %b expected %b", obs, 5'b00010);
        end
        LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        obs = {StallF, StallD, FlushE, EnE, FlushD};
        checks++;
        if (obs !== 5'b00010) begin
            errors++;
            $display("FAIL lw_x0_nostall: got %b expected %b", obs, 5'b00010);
        end
        RdE = 5'd12; Rs1D = 5'd12; Rs2D = 5'd1;
        #1;
        obs = {StallF, StallD, FlushE, EnE, FlushD};
        checks++;
        if (obs !== 5'b11110) begin
            errors++;
            $display("FAIL lw_stall_rs1: got %b expected %b", obs, 5'b11110);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    // {FlushD,FlushE,StallF,StallD,EnE}
    task automatic test_branch();
        logic [4:0] obs;
        clear_inputs();
        PCSrcE = 1'b1;
        #1;
        obs = {FlushD, FlushE, StallF, StallD, EnE};
        checks++;
        if (obs !== 5'b11001) begin
            errors++;
            $display("FAIL branch_flush: got %b expected %b", obs, 5'b11001);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    // {DivBusy,FlushM,EnE,DivDoneE,StallF}
    task automatic test_divide();
        logic [4:0] obs;
        do_reset();
        DivStartE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            obs = {DivBusy, FlushM, EnE, DivDoneE, StallF};
            checks++;
            if (obs !== 5'b11001) begin
                errors++;
                $display("FAIL div4_busy_c%0d: got %b expected %b", i, obs, 5'b11001);
            end
            @(negedge clk);
        end
        #1;
        obs = {DivBusy, FlushM, EnE, DivDoneE, StallF};
        checks++;
        if (obs !== 5'b00110) begin
            errors++;
            $display("FAIL div4_done: got %b expected %b", obs, 5'b00110);
        end
        DivStartE = 1'b0;
        @(negedge clk);
        #1;
        obs = {DivBusy, FlushM, EnE, DivDoneE, StallF};
        checks++;
        if (obs !== 5'b00100) begin
            errors++;
            $display("FAIL div4_idle_after: got %b expected %b", obs, 5'b00100);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs, exp;
        do_reset();
        DivStartE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp = {((i % 5) < 4) ? 1'b1 : 1'b0, ((i % 5) == 4) ? 1'b1 : 1'b0};
            obs = {DivBusy, DivDoneE};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_c%0d: got busy,done=%b expected %b", i, obs, exp);
            end
            @(negedge clk);
        end
        DivStartE = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div2_boundary();
        logic [1:0] obs, exp;
        do_reset();
        DivStartE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = {(i < 2) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0};
            obs = {d2_DivBusy, d2_DivDoneE};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div2_c%0d: got busy,done=%b expected %b", i, obs, exp);
            end
            @(negedge clk);
        end
        DivStartE = 1'b0;
        #1;
        obs = {d2_DivBusy, d2_DivDoneE};
        checks++;
        if (obs !== 2'b00) begin
            errors++;
            $display("FAIL div2_idle_after: got busy,done=%b expected %b", obs, 2'b00);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_divide();
        logic [3:0] obs;
        do_reset();
        DivStartE = 1'b1;
        repeat (2) @(negedge clk);
        // The held instruction leaves; the sequencer alone must keep DivBusy up.
        DivStartE = 1'b0;
        #1;
        checks++;
        if ({DivBusy, d2_DivDoneE} !== 2'b11) begin
            errors++;
            $display("FAIL mid_div_before_reset: got busy4,done2=%b expected %b", {DivBusy, d2_DivDoneE}, 2'b11);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({DivBusy, FlushM, EnE, d2_DivDoneE} !== 4'b0010) begin
            errors++;
            $display("FAIL mid_div_async_reset: got %b expected %b", {DivBusy, FlushM, EnE, d2_DivDoneE}, 4'b0010);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            obs = {DivBusy, DivDoneE, StallF, EnE};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("FAIL post_reset_idle_c%0d: got %b expected %b", i, obs, 4'b0001);
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_divide();
        test_back_to_back();
        test_div2_boundary();
        test_reset_mid_divide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
